// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_arbiter
// Purpose : Round-robin sharing of one UART transmitter among NUM_REQ clients;
//           latches the winner's byte, launches the frame, acks on frame end.
// Revision: 1.0
// ============================================================================
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int LAUNCH_TO = 64,
  localparam int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [8*NUM_REQ-1:0] i_req_data,
  output logic [NUM_REQ-1:0]   o_ack,
  output logic                 o_tx_start,
  output logic [7:0]           o_tx_data,
  input  logic                 i_tx_busy,
  output logic [ID_W-1:0]      o_owner,
  output logic                 o_active,
  output logic                 o_timeout_err,
  input  logic                 i_err_clr
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [7:0]      c_TO_LAST = 8'(LAUNCH_TO - 1);
  localparam logic [ID_W-1:0] c_ID_LAST = ID_W'(NUM_REQ - 1);

  logic [1:0]      r_state;
  logic            r_tx_start;
  logic [7:0]      r_tx_data;
  logic [ID_W-1:0] r_owner;
  logic [ID_W-1:0] r_rr_ptr;
  logic [7:0]      r_to_cnt;
  logic            r_timeout_err;

  logic            w_found;
  logic [ID_W-1:0] w_winner;
  int              w_idx;
  logic            w_to_set;
  logic [ID_W-1:0] w_rr_next;

  // Scan requesters starting at the round-robin pointer, wrapping modulo NUM_REQ.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= NUM_REQ) begin
        w_idx = w_idx - NUM_REQ;
      end
      if (!w_found && i_req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = ID_W'(w_idx);
      end
    end
  end

  assign w_to_set  = (r_state == S_LAUNCH) && !i_tx_busy && (r_to_cnt == c_TO_LAST);
  assign w_rr_next = (r_owner == c_ID_LAST) ? '0 : r_owner + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_tx_start    <= 1'b0;
      r_tx_data     <= 8'h00;
      r_owner       <= '0;
      r_rr_ptr      <= '0;
      r_to_cnt      <= 8'h00;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_en && w_found) begin
            r_owner    <= w_winner;
            r_tx_data  <= i_req_data[{w_winner, 3'b000} +: 8];
            r_tx_start <= 1'b1;
            r_to_cnt   <= 8'h00;
            r_state    <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          // tx_start stays high here until the UART reports busy, since it
          // only samples the strobe on its baud enable.
          if (i_tx_busy) begin
            r_tx_start <= 1'b0;
            r_state    <= S_DRAIN;
          end else if (r_to_cnt == c_TO_LAST) begin
            r_tx_start <= 1'b0;
            r_state    <= S_DONE;
          end else begin
            r_to_cnt <= r_to_cnt + 8'h01;
          end
        end
        S_DRAIN: begin
          if (!i_tx_busy) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_rr_ptr <= w_rr_next;
          r_state  <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      if (w_to_set) begin
        r_timeout_err <= 1'b1;
      end else if (i_err_clr) begin
        r_timeout_err <= 1'b0;
      end
    end
  end

  assign o_ack         = (r_state == S_DONE) ? (NUM_REQ'(1) << r_owner) : '0;
  assign o_tx_start    = r_tx_start;
  assign o_tx_data     = r_tx_data;
  assign o_owner       = r_owner;
  assign o_active      = (r_state != S_IDLE);
  assign o_timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx_arbiter
// Purpose : Scoreboard bench for uart_tx_arbiter with a behavioural UART model.
// Revision: 1.0
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int N    = 4;
  localparam int TO   = 8;
  localparam int ID_W = 2;

  logic              clk;
  logic              rst;
  logic              i_en;
  logic [N-1:0]      i_req;
  logic [8*N-1:0]    i_req_data;
  logic [N-1:0]      o_ack;
  logic              o_tx_start;
  logic [7:0]        o_tx_data;
  logic              i_tx_busy;
  logic [ID_W-1:0]   o_owner;
  logic              o_active;
  logic              o_timeout_err;
  logic              i_err_clr;

  uart_tx_arbiter #(.NUM_REQ(N), .LAUNCH_TO(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_en          (i_en),
    .i_req         (i_req),
    .i_req_data    (i_req_data),
    .o_ack         (o_ack),
    .o_tx_start    (o_tx_start),
    .o_tx_data     (o_tx_data),
    .i_tx_busy     (i_tx_busy),
    .o_owner       (o_owner),
    .o_active      (o_active),
    .o_timeout_err (o_timeout_err),
    .i_err_clr     (i_err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [ID_W+7:0] exp_grant_q[$];
  logic [N-1:0]    exp_ack_q[$];
  int              model_ptr = 0;

  int  fixed_d = 0;
  int  fixed_h = 0;
  bit  stuck   = 1'b0;
  int  d_cyc;
  int  h_cyc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: grant pending requesters in round-robin order from the pointer.
  task automatic model_batch(input logic [N-1:0] mask, input logic [31:0] data);
    logic [N-1:0] pend;
    int w;
    pend = mask;
    while (pend != 0) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        if (w < 0 && pend[(model_ptr + k) % N]) w = (model_ptr + k) % N;
      end
      exp_grant_q.push_back({ID_W'(w), data[8*w +: 8]});
      exp_ack_q.push_back(N'(1) << w);
      pend[w]   = 1'b0;
      model_ptr = (w + 1) % N;
    end
  endtask

  // UART model: busy rises d cycles after tx_start is seen, held h cycles.
  initial begin
    i_tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && o_tx_start && !stuck) begin
        d_cyc = (fixed_d != 0) ? fixed_d : int'($urandom_range(1, 4));
        h_cyc = (fixed_h != 0) ? fixed_h : int'($urandom_range(1, 12));
        repeat (d_cyc) @(negedge clk);
        i_tx_busy = 1'b1;
        for (int k = 0; k < h_cyc; k++) begin
          @(negedge clk);
          if (rst) break;
        end
        i_tx_busy = 1'b0;
      end
    end
  end

  // Requesters drop their request as soon as they see their ack.
  initial begin
    forever begin
      @(negedge clk);
      i_req = i_req & ~o_ack;
    end
  end

  // Monitor: compare each frame launch and each ack against the scoreboard.
  logic prev_start = 1'b0;
  logic [ID_W+7:0] g;
  logic [N-1:0]    a;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (o_tx_start && !prev_start) begin
          if (exp_grant_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_grant: got owner %0d data %0h expected none", o_owner, o_tx_data);
          end else begin
            g = exp_grant_q.pop_front();
            chk("grant_owner", 32'(o_owner), 32'(g[ID_W+7:8]));
            chk("grant_data", 32'(o_tx_data), 32'(g[7:0]));
          end
        end
        if (o_ack != 0) begin
          chk("ack_onehot", 32'($countones(o_ack)), 32'd1);
          if (exp_ack_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_ack: got %0h expected none", o_ack);
          end else begin
            a = exp_ack_q.pop_front();
            chk("ack_value", 32'(o_ack), 32'(a));
          end
        end
      end
      prev_start = o_tx_start;
    end
  end

  task automatic wait_idle(input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      if (exp_grant_q.size() == 0 && exp_ack_q.size() == 0 && !o_active && i_req == 0) done = 1'b1;
    end
    chk("idle_reached", 32'(done), 32'd1);
  endtask

  task automatic wait_busy(input logic level, input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(posedge clk);
      if (i_tx_busy == level) done = 1'b1;
    end
    chk("busy_level_reached", 32'(done), 32'd1);
  endtask

  task automatic run_batch(input logic [N-1:0] mask, input logic [31:0] data);
    @(negedge clk);
    i_req_data = data;
    model_batch(mask, data);
    i_req = mask;
    wait_idle(2000);
  endtask

  int cnt;

  initial begin
    rst = 1'b1; i_en = 1'b1; i_req = '0; i_req_data = '0; i_err_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(o_ack), 0);
    chk("rst_tx_start", 32'(o_tx_start), 0);
    chk("rst_tx_data", 32'(o_tx_data), 0);
    chk("rst_owner", 32'(o_owner), 0);
    chk("rst_active", 32'(o_active), 0);
    chk("rst_timeout_err", 32'(o_timeout_err), 0);
    rst = 1'b0;
    @(negedge clk);

    // Fairness, wrap-around and re-assertion of requester 0.
    run_batch(4'b1111, 32'h13121110);
    run_batch(4'b1010, 32'h3300_2200);
    run_batch(4'b0001, 32'h0000_0077);

    // Single requester with fixed UART timing.
    fixed_d = 3; fixed_h = 20;
    @(negedge clk);
    i_req_data = 32'h00A5_0000;
    model_batch(4'b0100, 32'h00A5_0000);
    i_req = 4'b0100;
    @(negedge clk);
    chk("t1_start_latency", 32'(o_tx_start), 1);
    wait_busy(1'b1, 100);
    wait_busy(1'b0, 100);
    @(negedge clk);
    chk("t1_ack", 32'(o_ack), 32'h4);
    wait_idle(200);

    // Launch timeout with the UART never going busy.
    stuck = 1'b1;
    @(negedge clk);
    i_req_data = 32'h0000_005C;
    model_batch(4'b0001, 32'h0000_005C);
    i_req = 4'b0001;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (o_tx_start) cnt++;
    end
    chk("t4_start_cycles", 32'(cnt), 32'd8);
    chk("t4_timeout_err", 32'(o_timeout_err), 1);
    wait_idle(100);
    stuck = 1'b0;
    i_err_clr = 1'b1;
    @(negedge clk);
    i_err_clr = 1'b0;
    chk("t4_err_cleared", 32'(o_timeout_err), 0);

    // Withdrawal of requester 2 while requester 0 drains.
    fixed_d = 2; fixed_h = 10;
    @(negedge clk);
    i_req_data = 32'h00EE_0031;
    model_batch(4'b0001, 32'h00EE_0031);
    i_req = 4'b0001;
    wait_busy(1'b1, 100);
    @(negedge clk);
    i_req = i_req | 4'b0100;
    @(negedge clk);
    i_req = i_req & 4'b1011;
    wait_idle(200);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (o_tx_start || o_active) cnt++;
    end
    chk("t6_no_regrant", 32'(cnt), 0);

    // en gating, then reset in DRAIN.
    fixed_d = 2; fixed_h = 20;
    @(negedge clk);
    i_en = 1'b0;
    i_req_data = 32'h0000_6B00;
    i_req = 4'b0010;
    cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (o_tx_start) cnt++;
    end
    chk("t5_en_gated", 32'(cnt), 0);
    exp_grant_q.push_back({2'd1, 8'h6B});
    i_en = 1'b1;
    wait_busy(1'b1, 100);
    @(negedge clk);
    chk("t5_owner", 32'(o_owner), 1);
    rst = 1'b1;
    i_req = '0;
    @(negedge clk);
    chk("t5_rst_ack", 32'(o_ack), 0);
    chk("t5_rst_tx_start", 32'(o_tx_start), 0);
    chk("t5_rst_tx_data", 32'(o_tx_data), 0);
    chk("t5_rst_owner", 32'(o_owner), 0);
    chk("t5_rst_active", 32'(o_active), 0);
    @(negedge clk);
    rst = 1'b0;
    model_ptr = 0;
    repeat (3) @(negedge clk);

    // Randomized batches with random UART timing.
    fixed_d = 0; fixed_h = 0;
    for (int p = 0; p < 25; p++) begin
      run_batch(N'($urandom_range(1, 15)), $urandom);
    end

    chk("grant_q_drained", 32'(exp_grant_q.size()), 0);
    chk("ack_q_drained", 32'(exp_ack_q.size()), 0);
    chk("final_timeout_err", 32'(o_timeout_err), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
